lrn_window_buffer: RTL and testbench

Channel-window buffer and local-sum engine for the LRN layer. It sits between the activation memory read port and the LRN divider, in parallel with the LRN address mapper. It captures one spatial position's channel vector (dim3 samples) from memory, raises `full_flag`, and computes a sliding cross-channel sum of squares. For each channel it issues a numerator/denominator pair to the divider, then pulses `normalized_window` so the mapper can fetch the next position.

---
 rtl/lrn_window_buffer.sv | 179 +++++++++++++++++
 tb/tb_lrn_window_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lrn_window_buffer.sv
// Channel-window buffer for LRN: captures one position's channel vector, then streams
// (pix[c], K + (ALPHA * window sum of squares) >> SHIFT) pairs to the divider.
module lrn_window_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int M_WIDTH     = 10,
    parameter int MAX_CH      = 64,
    parameter int LOCAL_SIZE  = 5,
    parameter int ALPHA       = 1,
    parameter int ALPHA_SHIFT = 0,
    parameter int K_CONST     = 1,
    parameter int DEN_WIDTH   = 32
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic [M_WIDTH-1:0]    dim3,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  full_flag,
    output logic                  div_in_valid,
    input  logic                  div_in_ready,
    output logic [DATA_WIDTH-1:0] div_numerator,
    output logic [DEN_WIDTH-1:0]  div_denominator,
    output logic                  normalized_window,
    output logic                  overflow
);

    localparam int AW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int R  = LOCAL_SIZE / 2;
    localparam int SW = 2 * DATA_WIDTH + $clog2(LOCAL_SIZE);
    localparam int PW = SW + 17;

    localparam logic [M_WIDTH-1:0] R_M       = M_WIDTH'(R);
    localparam logic [M_WIDTH:0]   R1_M      = (M_WIDTH + 1)'(R + 1);
    localparam logic [M_WIDTH:0]   MAX_CH_M  = (M_WIDTH + 1)'(MAX_CH);
    localparam logic [PW-1:0]      ONE_P     = 1;
    localparam logic [PW-1:0]      ALPHA_P   = PW'(ALPHA);
    localparam logic [PW-1:0]      K_P       = PW'(K_CONST);
    localparam logic [PW-1:0]      DEN_MAX_P = (ONE_P << DEN_WIDTH) - ONE_P;

    typedef enum logic [1:0] {S_FILL, S_PRIME, S_ISSUE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [M_WIDTH-1:0]   cnt_q, cnt_d;
    logic [M_WIDTH-1:0]   c_q, c_d;
    logic [M_WIDTH-1:0]   n_q, n_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic                 overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]   pix_mem [MAX_CH];
    logic [2*DATA_WIDTH-1:0] sq_mem  [MAX_CH];

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [2*DATA_WIDTH-1:0] wr_sq;
    logic [M_WIDTH-1:0]      n_eff;
    logic [M_WIDTH-1:0]      prime_end;
    logic [AW-1:0]           add_addr;
    logic [AW-1:0]           sub_addr;
    logic                    add_en;
    logic                    sub_en;
    logic [PW-1:0]           prod;
    logic [PW-1:0]           biased;
    logic [DEN_WIDTH-1:0]    den_sat;

    // Buffer storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            pix_mem[wr_addr] <= rd_data;
            sq_mem[wr_addr]  <= wr_sq;
        end
    end

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state_q    <= S_FILL;
            cnt_q      <= '0;
            c_q        <= '0;
            n_q        <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            n_q        <= n_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        wr_addr   = cnt_q[AW-1:0];
        wr_sq     = (2*DATA_WIDTH)'(rd_data) * (2*DATA_WIDTH)'(rd_data);
        n_eff     = (cnt_q == '0) ? dim3 : n_q;
        prime_end = ((n_q - 1'b1) < R_M) ? (n_q - 1'b1) : R_M;
        add_addr  = c_q[AW-1:0] + AW'(R + 1);
        sub_addr  = c_q[AW-1:0] - AW'(R);
        add_en    = ({1'b0, c_q} + R1_M) < {1'b0, n_q};
        sub_en    = c_q >= R_M;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        c_d        = c_q;
        n_d        = n_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;

        if (rd_valid && state_q != S_FILL) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            S_FILL: begin
                if (rd_valid) begin
                    // dim3 is only trusted on the first sample of a window
                    if (cnt_q == '0 && (dim3 == '0 || {1'b0, dim3} > MAX_CH_M)) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == '0) begin
                            n_d = dim3;
                        end
                        if (cnt_q == n_eff - 1'b1) begin
                            state_d = S_PRIME;
                            c_d     = '0;
                            sum_d   = '0;
                        end
                    end
                end
            end
            S_PRIME: begin
                sum_d = sum_q + SW'(sq_mem[c_q[AW-1:0]]);
                if (c_q == prime_end) begin
                    state_d = S_ISSUE;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (div_in_ready) begin
                    sum_d = sum_q
                          + (add_en ? SW'(sq_mem[add_addr]) : '0)
                          - (sub_en ? SW'(sq_mem[sub_addr]) : '0);
                    c_d   = c_q + 1'b1;
                    if (c_q == n_q - 1'b1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_FILL;
                cnt_d   = '0;
                c_d     = '0;
                sum_d   = '0;
            end
            default: state_d = S_FILL;
        endcase
    end

    // Full-width product and bias so saturation is decided on the exact value.
    always_comb begin
        prod    = ALPHA_P * PW'(sum_q);
        biased  = (prod >> ALPHA_SHIFT) + K_P;
        den_sat = (biased > DEN_MAX_P) ? '1 : DEN_WIDTH'(biased);
    end

    assign full_flag         = (state_q == S_PRIME) || (state_q == S_ISSUE);
    assign div_in_valid      = (state_q == S_ISSUE);
    assign div_numerator     = (state_q == S_ISSUE) ? pix_mem[c_q[AW-1:0]] : '0;
    assign div_denominator   = (state_q == S_ISSUE) ? den_sat : '0;
    assign normalized_window = (state_q == S_DONE);
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_lrn_window_buffer.sv
// Directed scoreboard bench for lrn_window_buffer: three instances cover default,
// 16-bit saturating denominator, and ALPHA=3/SHIFT=1 scaling.
module tb_lrn_window_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  dim3;
    logic [15:0] rd_data;
    logic        ready;
    logic        rv   [3];
    logic        full [3];
    logic        vld  [3];
    logic        nw   [3];
    logic        ovf  [3];
    logic [15:0] num  [3];
    logic [31:0] den0;
    logic [15:0] den1;
    logic [31:0] den2;

    always #5 clk = ~clk;

    lrn_window_buffer u_dut0 (
        .core_clk(clk), .reset(reset), .dim3(dim3), .rd_data(rd_data), .rd_valid(rv[0]),
        .full_flag(full[0]), .div_in_valid(vld[0]), .div_in_ready(ready),
        .div_numerator(num[0]), .div_denominator(den0),
        .normalized_window(nw[0]), .overflow(ovf[0])
    );

    lrn_window_buffer #(.DEN_WIDTH(16)) u_dut1 (
        .core_clk(clk), .reset(reset), .dim3(dim3), .rd_data(rd_data), .rd_valid(rv[1]),
        .full_flag(full[1]), .div_in_valid(vld[1]), .div_in_ready(ready),
        .div_numerator(num[1]), .div_denominator(den1),
        .normalized_window(nw[1]), .overflow(ovf[1])
    );

    lrn_window_buffer #(.ALPHA(3), .ALPHA_SHIFT(1)) u_dut2 (
        .core_clk(clk), .reset(reset), .dim3(dim3), .rd_data(rd_data), .rd_valid(rv[2]),
        .full_flag(full[2]), .div_in_valid(vld[2]), .div_in_ready(ready),
        .div_numerator(num[2]), .div_denominator(den2),
        .normalized_window(nw[2]), .overflow(ovf[2])
    );

    typedef struct packed {
        logic [15:0] num;
        logic [31:0] den;
    } pair_t;

    pair_t       exp_q [$];
    int          cur_sel;
    int          win_data [16];
    int          checks;
    int          errors;
    logic        full_o, vld_o, nw_o, ovf_o;
    logic [15:0] num_o;
    logic [31:0] den_o;

    always_comb begin
        full_o = full[cur_sel];
        vld_o  = vld[cur_sel];
        nw_o   = nw[cur_sel];
        ovf_o  = ovf[cur_sel];
        num_o  = num[cur_sel];
        case (cur_sel)
            1:       den_o = {16'h0000, den1};
            2:       den_o = den2;
            default: den_o = den0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Direct windowed sum over [c-2, c+2] clipped to the channel range.
    function automatic longint unsigned exp_den(input int sel, input int n, input int c);
        longint unsigned s = 0;
        longint unsigned v;
        longint unsigned mx;
        longint unsigned alpha = (sel == 2) ? 3 : 1;
        int              sh    = (sel == 2) ? 1 : 0;
        int              w     = (sel == 1) ? 16 : 32;
        for (int j = c - 2; j <= c + 2; j++) begin
            if (j >= 0 && j < n) s += longint'(win_data[j]) * longint'(win_data[j]);
        end
        v  = ((alpha * s) >> sh) + 1;
        mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic fill(input int n);
        pair_t p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) chk("full_before_last", full_o, 0);
            dim3         = 10'(n);
            rd_data      = 16'(win_data[i]);
            rv[cur_sel]  = 1'b1;
            p.num        = 16'(win_data[i]);
            p.den        = 32'(exp_den(cur_sel, n, i));
            exp_q.push_back(p);
        end
        @(negedge clk);
        rv[cur_sel] = 1'b0;
        chk("full_rise", full_o, 1);
    endtask

    // Called positioned at the negedge where full_flag first reads high.
    task automatic drain(input int n, input int mode, input int abort_after, input bit inject);
        int          cyc     = 0;
        int          acc     = 0;
        int          first   = -1;
        int          m       = (n - 1 < 2) ? n - 1 : 2;
        bit          stalled = 0;
        bit          done    = 0;
        logic [15:0] hn;
        logic [31:0] hd;
        pair_t       p;
        while (!done && cyc < 300) begin
            ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (stalled) begin
                chk("hold_num", num_o, hn);
                chk("hold_den", den_o, hd);
                stalled = 0;
            end
            if (vld_o) begin
                if (first < 0) begin
                    first = cyc;
                    chk("first_valid_latency", cyc, m + 1);
                end
                if (abort_after >= 0 && acc == abort_after) begin
                    reset = 1'b1;
                    ready = 1'b0;
                    @(negedge clk);
                    chk("rst_full", full_o, 0);
                    chk("rst_valid", vld_o, 0);
                    chk("rst_num", num_o, 0);
                    chk("rst_den", den_o, 0);
                    chk("rst_nw", nw_o, 0);
                    chk("rst_ovf", ovf_o, 0);
                    reset = 1'b0;
                    exp_q.delete();
                    return;
                end
                if (inject && acc == 1) rv[cur_sel] = 1'b1;
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pair", 1, 0);
                    end else begin
                        p = exp_q.pop_front();
                        $display("pair sel=%0d c=%0d num=%0d den=%0d", cur_sel, acc, num_o, den_o);
                        chk("pair_num", num_o, p.num);
                        chk("pair_den", den_o, p.den);
                    end
                    acc++;
                end else begin
                    stalled = 1;
                    hn      = num_o;
                    hd      = den_o;
                end
            end
            if (nw_o) begin
                chk("done_full_low", full_o, 0);
                chk("done_pair_count", acc, n);
                chk("done_queue_empty", exp_q.size(), 0);
                done = 1;
            end
            @(negedge clk);
            cyc++;
            rv[cur_sel] = 1'b0;
        end
        if (!done) chk("drain_timeout", 0, 1);
        chk("pulse_one_cycle", nw_o, 0);
        chk("fill_full_low", full_o, 0);
    endtask

    task automatic set_ramp(input int n);
        for (int i = 0; i < n; i++) win_data[i] = i + 1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cur_sel = 0;
        reset   = 1'b1;
        dim3    = '0;
        rd_data = '0;
        ready   = 1'b0;
        for (int i = 0; i < 3; i++) rv[i] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_full", full_o, 0);
        chk("reset_valid", vld_o, 0);
        chk("reset_num", num_o, 0);
        chk("reset_den", den_o, 0);
        chk("reset_nw", nw_o, 0);
        chk("reset_ovf", ovf_o, 0);

        set_ramp(6);
        fill(6);
        drain(6, 0, -1, 0);
        chk("basic_ovf_clear", ovf_o, 0);

        fill(6);
        drain(6, 1, -1, 0);

        win_data[0] = 7;
        fill(1);
        drain(1, 0, -1, 0);

        set_ramp(6);
        fill(6);
        drain(6, 0, -1, 1);
        chk("ovf_issue_sticky", ovf_o, 1);

        fill(6);
        drain(6, 0, 2, 0);
        for (int i = 0; i < 3; i++) win_data[i] = 1;
        fill(3);
        drain(3, 0, -1, 0);

        @(negedge clk);
        dim3     = 10'd0;
        rd_data  = 16'd5;
        rv[0]    = 1'b1;
        @(negedge clk);
        rv[0]    = 1'b0;
        chk("ovf_dim3_zero", ovf_o, 1);
        chk("ovf_dim3_no_full", full_o, 0);
        set_ramp(6);
        fill(6);
        drain(6, 0, -1, 0);
        chk("ovf_still_set", ovf_o, 1);

        cur_sel     = 1;
        win_data[0] = 16'hFFFF;
        win_data[1] = 16'hFFFF;
        fill(2);
        drain(2, 0, -1, 0);

        cur_sel     = 2;
        win_data[0] = 2;
        win_data[1] = 2;
        fill(2);
        drain(2, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
